// File: rtl/fb_arb_pkg.sv
// Shared types for the framebuffer SRAM arbiter: FSM states and transfer direction.
package fb_arb_pkg;

   typedef enum logic [1:0] {
      ARB   = 2'd0,
      TURN  = 2'd1,
      GRANT = 2'd2
   } arb_state_t;

   typedef enum logic {
      DIR_READ  = 1'b0,
      DIR_WRITE = 1'b1
   } dir_t;

endpackage

// File: rtl/fb_sram_arbiter_if.sv
// Requester and SRAM-controller bus bundle for the framebuffer arbiter.
interface fb_sram_arbiter_if #(
   parameter int ADDR_BITS = 20,
   parameter int DATA_BITS = 16
);
   logic                 rd_valid;
   logic                 rd_ready;
   logic [ADDR_BITS-1:0] rd_addr;
   logic                 wr_valid;
   logic                 wr_ready;
   logic [ADDR_BITS-1:0] wr_addr;
   logic [DATA_BITS-1:0] wr_data;
   logic                 mem_cmd_valid;
   logic                 mem_cmd_ready;
   logic                 mem_cmd_we;
   logic [ADDR_BITS-1:0] mem_cmd_addr;
   logic [DATA_BITS-1:0] mem_cmd_wdata;
   logic                 mem_rd_valid;
   logic [DATA_BITS-1:0] mem_rd_data;
   logic                 rd_data_valid;
   logic [DATA_BITS-1:0] rd_data;

   modport slave (
      input  rd_valid, rd_addr, wr_valid, wr_addr, wr_data,
      input  mem_cmd_ready, mem_rd_valid, mem_rd_data,
      output rd_ready, wr_ready, mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_cmd_wdata,
      output rd_data_valid, rd_data
   );

   modport master (
      output rd_valid, rd_addr, wr_valid, wr_addr, wr_data,
      output mem_cmd_ready, mem_rd_valid, mem_rd_data,
      input  rd_ready, wr_ready, mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_cmd_wdata,
      input  rd_data_valid, rd_data
   );
endinterface

// File: rtl/fb_sram_arbiter.sv
// Read-priority arbiter sharing one SRAM command port between scanline reads and pixel
// writes, with bounded write wait and idle gaps on every bus direction change.
module fb_sram_arbiter
   import fb_arb_pkg::*;
#(
   parameter int ADDR_BITS    = 20,
   parameter int DATA_BITS    = 16,
   parameter int MAX_RD_BURST = 8,
   parameter int TURN_CYCLES  = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   fb_sram_arbiter_if.slave bus
);
   localparam int BW = $clog2(MAX_RD_BURST + 1);
   localparam int TW = (TURN_CYCLES < 2) ? 1 : $clog2(TURN_CYCLES + 1);
   localparam logic [BW-1:0] MAX_BURST = BW'(MAX_RD_BURST);

   arb_state_t           state_q, state_d;
   dir_t                 last_dir_q, last_dir_d, new_dir_q, new_dir_d, pick_dir_s;
   logic [BW-1:0]        burst_cnt_q, burst_cnt_d;
   logic [TW-1:0]        turn_cnt_q, turn_cnt_d;
   logic                 pick_vld_s, free_s, grant_vld_s, rd_acc_s, wr_acc_s;
   logic                 cmd_valid_q, cmd_valid_d, cmd_we_q, cmd_we_d;
   logic [ADDR_BITS-1:0] cmd_addr_q, cmd_addr_d;
   logic [DATA_BITS-1:0] cmd_wdata_q, cmd_wdata_d;

   assign free_s      = !cmd_valid_q || bus.mem_cmd_ready;
   assign pick_vld_s  = bus.rd_valid || bus.wr_valid;
   assign pick_dir_s  = (bus.rd_valid && (!bus.wr_valid || (burst_cnt_q < MAX_BURST)))
                        ? DIR_READ : DIR_WRITE;
   assign grant_vld_s = (last_dir_q == DIR_READ) ? bus.rd_valid : bus.wr_valid;

   // FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ARB;
         last_dir_q <= DIR_READ;
         new_dir_q  <= DIR_READ;
         turn_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         last_dir_q <= last_dir_d;
         new_dir_q  <= new_dir_d;
         turn_cnt_q <= turn_cnt_d;
      end
   end

   // FSM next state; the decision cycle in ARB is itself the first idle turnaround cycle
   always_comb begin
      state_d    = state_q;
      last_dir_d = last_dir_q;
      new_dir_d  = new_dir_q;
      turn_cnt_d = turn_cnt_q;
      case (state_q)
         ARB: begin
            if (pick_vld_s && free_s && (pick_dir_s != last_dir_q)) begin
               if (TURN_CYCLES == 0) begin
                  last_dir_d = pick_dir_s;
               end else if (TURN_CYCLES == 1) begin
                  state_d    = GRANT;
                  last_dir_d = pick_dir_s;
               end else begin
                  state_d    = TURN;
                  turn_cnt_d = TW'(TURN_CYCLES);
                  new_dir_d  = pick_dir_s;
               end
            end else begin
               state_d = ARB;
            end
         end
         TURN: begin
            turn_cnt_d = turn_cnt_q - TW'(1);
            if (turn_cnt_d == TW'(1)) begin
               state_d    = GRANT;
               last_dir_d = new_dir_q;
            end else begin
               state_d = TURN;
            end
         end
         GRANT: begin
            if (!grant_vld_s || free_s) begin
               state_d = ARB;
            end else begin
               state_d = GRANT;
            end
         end
         default: state_d = ARB;
      endcase
   end

   // FSM outputs: which requester is accepted this cycle
   always_comb begin
      rd_acc_s = 1'b0;
      wr_acc_s = 1'b0;
      case (state_q)
         ARB: begin
            if (pick_vld_s && free_s && ((pick_dir_s == last_dir_q) || (TURN_CYCLES == 0))) begin
               rd_acc_s = (pick_dir_s == DIR_READ);
               wr_acc_s = (pick_dir_s == DIR_WRITE);
            end else begin
               rd_acc_s = 1'b0;
               wr_acc_s = 1'b0;
            end
         end
         GRANT: begin
            if (grant_vld_s && free_s) begin
               rd_acc_s = (last_dir_q == DIR_READ);
               wr_acc_s = (last_dir_q == DIR_WRITE);
            end else begin
               rd_acc_s = 1'b0;
               wr_acc_s = 1'b0;
            end
         end
         default: begin
            rd_acc_s = 1'b0;
            wr_acc_s = 1'b0;
         end
      endcase
   end

   // Command register load and read-burst accounting
   always_comb begin
      cmd_valid_d = cmd_valid_q;
      cmd_we_d    = cmd_we_q;
      cmd_addr_d  = cmd_addr_q;
      cmd_wdata_d = cmd_wdata_q;
      burst_cnt_d = burst_cnt_q;
      if (rd_acc_s) begin
         cmd_valid_d = 1'b1;
         cmd_we_d    = 1'b0;
         cmd_addr_d  = bus.rd_addr;
         cmd_wdata_d = '0;
      end else if (wr_acc_s) begin
         cmd_valid_d = 1'b1;
         cmd_we_d    = 1'b1;
         cmd_addr_d  = bus.wr_addr;
         cmd_wdata_d = bus.wr_data;
      end else if (free_s) begin
         cmd_valid_d = 1'b0;
      end else begin
         cmd_valid_d = cmd_valid_q;
      end
      if (!bus.wr_valid || wr_acc_s) begin
         burst_cnt_d = '0;
      end else if (rd_acc_s && (burst_cnt_q < MAX_BURST)) begin
         burst_cnt_d = burst_cnt_q + BW'(1);
      end else begin
         burst_cnt_d = burst_cnt_q;
      end
   end

   // Command output register and burst counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cmd_valid_q <= 1'b0;
         cmd_we_q    <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_wdata_q <= '0;
         burst_cnt_q <= '0;
      end else begin
         cmd_valid_q <= cmd_valid_d;
         cmd_we_q    <= cmd_we_d;
         cmd_addr_q  <= cmd_addr_d;
         cmd_wdata_q <= cmd_wdata_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   assign bus.rd_ready      = rd_acc_s;
   assign bus.wr_ready      = wr_acc_s;
   assign bus.mem_cmd_valid = cmd_valid_q;
   assign bus.mem_cmd_we    = cmd_we_q;
   assign bus.mem_cmd_addr  = cmd_addr_q;
   assign bus.mem_cmd_wdata = cmd_wdata_q;
   assign bus.rd_data_valid = bus.mem_rd_valid;
   assign bus.rd_data       = bus.mem_rd_data;

endmodule

// File: tb/tb_fb_sram_arbiter.sv
// Scoreboard bench for fb_sram_arbiter; three instances share stimulus with turnaround
// gaps of 1, 0 and 2 cycles.
module tb_fb_sram_arbiter;

   typedef struct packed {
      logic        v;
      logic        we;
      logic [19:0] a;
      logic [15:0] d;
   } cmd_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        rd_valid, wr_valid, mem_cmd_ready, mem_rd_valid;
   logic [19:0] rd_addr, wr_addr;
   logic [15:0] wr_data, mem_rd_data;

   logic        rdy_r [3];
   logic        rdy_w [3];
   logic        cv    [3];
   logic        cwe   [3];
   logic [19:0] ca    [3];
   logic [15:0] cwd   [3];

   cmd_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   fb_sram_arbiter_if #(.ADDR_BITS(20), .DATA_BITS(16)) bus0 ();
   fb_sram_arbiter_if #(.ADDR_BITS(20), .DATA_BITS(16)) bus1 ();
   fb_sram_arbiter_if #(.ADDR_BITS(20), .DATA_BITS(16)) bus2 ();

   fb_sram_arbiter #(.ADDR_BITS(20), .DATA_BITS(16), .MAX_RD_BURST(8), .TURN_CYCLES(1))
      dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0.slave));
   fb_sram_arbiter #(.ADDR_BITS(20), .DATA_BITS(16), .MAX_RD_BURST(8), .TURN_CYCLES(0))
      dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1.slave));
   fb_sram_arbiter #(.ADDR_BITS(20), .DATA_BITS(16), .MAX_RD_BURST(8), .TURN_CYCLES(2))
      dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2.slave));

   assign bus0.rd_valid = rd_valid;   assign bus0.rd_addr = rd_addr;
   assign bus0.wr_valid = wr_valid;   assign bus0.wr_addr = wr_addr;   assign bus0.wr_data = wr_data;
   assign bus0.mem_cmd_ready = mem_cmd_ready;
   assign bus0.mem_rd_valid = mem_rd_valid;   assign bus0.mem_rd_data = mem_rd_data;
   assign bus1.rd_valid = rd_valid;   assign bus1.rd_addr = rd_addr;
   assign bus1.wr_valid = wr_valid;   assign bus1.wr_addr = wr_addr;   assign bus1.wr_data = wr_data;
   assign bus1.mem_cmd_ready = mem_cmd_ready;
   assign bus1.mem_rd_valid = mem_rd_valid;   assign bus1.mem_rd_data = mem_rd_data;
   assign bus2.rd_valid = rd_valid;   assign bus2.rd_addr = rd_addr;
   assign bus2.wr_valid = wr_valid;   assign bus2.wr_addr = wr_addr;   assign bus2.wr_data = wr_data;
   assign bus2.mem_cmd_ready = mem_cmd_ready;
   assign bus2.mem_rd_valid = mem_rd_valid;   assign bus2.mem_rd_data = mem_rd_data;

   assign rdy_r[0] = bus0.rd_ready;  assign rdy_w[0] = bus0.wr_ready;
   assign rdy_r[1] = bus1.rd_ready;  assign rdy_w[1] = bus1.wr_ready;
   assign rdy_r[2] = bus2.rd_ready;  assign rdy_w[2] = bus2.wr_ready;
   assign cv[0] = bus0.mem_cmd_valid;  assign cwe[0] = bus0.mem_cmd_we;
   assign cv[1] = bus1.mem_cmd_valid;  assign cwe[1] = bus1.mem_cmd_we;
   assign cv[2] = bus2.mem_cmd_valid;  assign cwe[2] = bus2.mem_cmd_we;
   assign ca[0] = bus0.mem_cmd_addr;   assign cwd[0] = bus0.mem_cmd_wdata;
   assign ca[1] = bus1.mem_cmd_addr;   assign cwd[1] = bus1.mem_cmd_wdata;
   assign ca[2] = bus2.mem_cmd_addr;   assign cwd[2] = bus2.mem_cmd_wdata;

   function automatic int turn_of(int k);
      return (k == 0) ? 1 : ((k == 1) ? 0 : 2);
   endfunction

   // 0 = idle, 1 = read accept, 2 = write accept, for continuous read+write demand
   function automatic int exp_kind(int t, int c);
      int p;
      p = c % (9 + 2 * t);
      if (p < 8) return 1;
      if (p == 8 + t) return 2;
      return 0;
   endfunction

   task automatic do_reset();
      reset_n       = 1'b0;
      rd_valid      = 1'b0;
      wr_valid      = 1'b0;
      rd_addr       = 20'h0;
      wr_addr       = 20'h0;
      wr_data       = 16'h0;
      mem_cmd_ready = 1'b1;
      mem_rd_valid  = 1'b0;
      mem_rd_data   = 16'h0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #2;
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n       = 1'b0;
      rd_valid      = 1'b0;
      wr_valid      = 1'b0;
      rd_addr       = 20'h0;
      wr_addr       = 20'h0;
      wr_data       = 16'h0;
      mem_cmd_ready = 1'b1;
      mem_rd_valid  = 1'b0;
      mem_rd_data   = 16'h0;
      #3;
      for (int k = 0; k < 3; k++) begin
         total++;
         if (cv[k] !== 1'b0 || cwe[k] !== 1'b0 || ca[k] !== 20'h0 || cwd[k] !== 16'h0) begin
            bad++;
            $display("FAIL reset_cmd k=%0d got=%b/%b/%h/%h want=0/0/00000/0000",
                     k, cv[k], cwe[k], ca[k], cwd[k]);
         end
         total++;
         if (rdy_r[k] !== 1'b0 || rdy_w[k] !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready k=%0d got=%b/%b want=0/0", k, rdy_r[k], rdy_w[k]);
         end
      end
   endtask

   task automatic test_reads_only();
      cmd_t e;
      logic exp_rdy;
      do_reset();
      rd_valid = 1'b1;
      rd_addr  = 20'h00100;
      #1;
      for (int i = 0; i < 11; i++) begin
         if (i > 0) begin
            e = exp_q.pop_front();
            total++;
            if (cv[0] !== e.v || (e.v && (cwe[0] !== e.we || ca[0] !== e.a || cwd[0] !== e.d))) begin
               bad++;
               $display("FAIL rdonly_cmd i=%0d got=%b/%b/%h/%h want=%b/%b/%h/%h",
                        i, cv[0], cwe[0], ca[0], cwd[0], e.v, e.we, e.a, e.d);
            end
         end
         exp_rdy = (i < 10);
         total++;
         if (rdy_r[0] !== exp_rdy || rdy_w[0] !== 1'b0) begin
            bad++;
            $display("FAIL rdonly_ready i=%0d got=%b/%b want=%b/0", i, rdy_r[0], rdy_w[0], exp_rdy);
         end
         exp_q.push_back(exp_rdy ? cmd_t'{1'b1, 1'b0, rd_addr, 16'h0} : cmd_t'{1'b0, 1'b0, 20'h0, 16'h0});
         @(posedge clk);
         #1;
         if (exp_rdy) rd_addr = rd_addr + 20'h1;
         if (i == 9) rd_valid = 1'b0;
         #1;
      end
      e = exp_q.pop_front();
      total++;
      if (cv[0] !== e.v) begin
         bad++;
         $display("FAIL rdonly_tail got=%b want=%b", cv[0], e.v);
      end
   endtask

   task automatic test_mixed();
      cmd_t e;
      int   kind;
      do_reset();
      rd_valid = 1'b1;
      rd_addr  = 20'h0AAAA;
      wr_valid = 1'b1;
      wr_addr  = 20'h05555;
      wr_data  = 16'h1234;
      #1;
      for (int c = 0; c <= 40; c++) begin
         for (int k = 0; k < 3; k++) begin
            if (c > 0) begin
               e = exp_q.pop_front();
               total++;
               if (cv[k] !== e.v || (e.v && (cwe[k] !== e.we || ca[k] !== e.a || cwd[k] !== e.d))) begin
                  bad++;
                  $display("FAIL mixed_cmd k=%0d c=%0d got=%b/%b/%h/%h want=%b/%b/%h/%h",
                           k, c, cv[k], cwe[k], ca[k], cwd[k], e.v, e.we, e.a, e.d);
               end
            end
            if (c < 40) begin
               kind = exp_kind(turn_of(k), c);
               total++;
               if (rdy_r[k] !== (kind == 1) || rdy_w[k] !== (kind == 2)) begin
                  bad++;
                  $display("FAIL mixed_ready k=%0d c=%0d got=%b/%b want=%b/%b",
                           k, c, rdy_r[k], rdy_w[k], kind == 1, kind == 2);
               end
               case (kind)
                  1:       exp_q.push_back(cmd_t'{1'b1, 1'b0, rd_addr, 16'h0});
                  2:       exp_q.push_back(cmd_t'{1'b1, 1'b1, wr_addr, wr_data});
                  default: exp_q.push_back(cmd_t'{1'b0, 1'b0, 20'h0, 16'h0});
               endcase
            end
         end
         @(posedge clk);
         #2;
      end
      rd_valid = 1'b0;
      wr_valid = 1'b0;
   endtask

   task automatic test_stall();
      int n;
      do_reset();
      wr_valid = 1'b1;
      wr_addr  = 20'h12345;
      wr_data  = 16'hBEEF;
      #1;
      n = 0;
      while (rdy_w[0] !== 1'b1 && n < 8) begin
         @(posedge clk);
         #2;
         n++;
      end
      total++;
      if (n !== 1) begin
         bad++;
         $display("FAIL stall_first_grant got_cycles=%0d want=1", n);
      end
      mem_cmd_ready = 1'b0;
      @(posedge clk);
      #1;
      wr_addr = 20'h00055;
      wr_data = 16'h1111;
      #1;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (cv[0] !== 1'b1 || cwe[0] !== 1'b1 || ca[0] !== 20'h12345 || cwd[0] !== 16'hBEEF) begin
            bad++;
            $display("FAIL stall_hold i=%0d got=%b/%b/%h/%h want=1/1/12345/beef",
                     i, cv[0], cwe[0], ca[0], cwd[0]);
         end
         total++;
         if (rdy_r[0] !== 1'b0 || rdy_w[0] !== 1'b0) begin
            bad++;
            $display("FAIL stall_ready i=%0d got=%b/%b want=0/0", i, rdy_r[0], rdy_w[0]);
         end
         if (i < 3) begin
            @(posedge clk);
            #2;
         end
      end
      mem_cmd_ready = 1'b1;
      #1;
      total++;
      if (rdy_w[0] !== 1'b1) begin
         bad++;
         $display("FAIL stall_release got=%b want=1", rdy_w[0]);
      end
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
      #1;
      total++;
      if (cv[0] !== 1'b1 || cwe[0] !== 1'b1 || ca[0] !== 20'h00055 || cwd[0] !== 16'h1111) begin
         bad++;
         $display("FAIL stall_next got=%b/%b/%h/%h want=1/1/00055/1111", cv[0], cwe[0], ca[0], cwd[0]);
      end
   endtask

   task automatic test_reset_in_turn();
      int n;
      do_reset();
      wr_valid = 1'b1;
      wr_addr  = 20'h0ABCD;
      wr_data  = 16'h5A5A;
      #1;
      n = 0;
      while (rdy_w[0] !== 1'b1 && n < 8) begin
         @(posedge clk);
         #2;
         n++;
      end
      total++;
      if (rdy_w[0] !== 1'b1) begin
         bad++;
         $display("FAIL rstturn_grant_timeout got=%b want=1", rdy_w[0]);
      end
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
      rd_valid = 1'b1;
      rd_addr  = 20'h00777;
      #1;
      total++;
      if (cv[0] !== 1'b1 || rdy_r[0] !== 1'b0) begin
         bad++;
         $display("FAIL rstturn_gap got=%b/%b want=1/0", cv[0], rdy_r[0]);
      end
      reset_n = 1'b0;
      #1;
      total++;
      if (cv[0] !== 1'b0 || cwe[0] !== 1'b0 || ca[0] !== 20'h0 || cwd[0] !== 16'h0) begin
         bad++;
         $display("FAIL rstturn_drop got=%b/%b/%h/%h want=0/0/00000/0000", cv[0], cwe[0], ca[0], cwd[0]);
      end
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      total++;
      if (rdy_r[0] !== 1'b1 || rdy_w[0] !== 1'b0) begin
         bad++;
         $display("FAIL rstturn_first_read got=%b/%b want=1/0", rdy_r[0], rdy_w[0]);
      end
      @(posedge clk);
      #1;
      rd_valid = 1'b0;
      #1;
      total++;
      if (cv[0] !== 1'b1 || cwe[0] !== 1'b0 || ca[0] !== 20'h00777 || cwd[0] !== 16'h0) begin
         bad++;
         $display("FAIL rstturn_cmd got=%b/%b/%h/%h want=1/0/00777/0000", cv[0], cwe[0], ca[0], cwd[0]);
      end
   endtask

   task automatic test_rd_return();
      mem_rd_data  = 16'hA5A5;
      mem_rd_valid = 1'b1;
      #1;
      total++;
      if (bus0.rd_data_valid !== 1'b1 || bus0.rd_data !== 16'hA5A5) begin
         bad++;
         $display("FAIL rdret_pulse got=%b/%h want=1/a5a5", bus0.rd_data_valid, bus0.rd_data);
      end
      mem_rd_valid = 1'b0;
      mem_rd_data  = 16'h3C3C;
      #1;
      total++;
      if (bus0.rd_data_valid !== 1'b0 || bus0.rd_data !== 16'h3C3C) begin
         bad++;
         $display("FAIL rdret_idle got=%b/%h want=0/3c3c", bus0.rd_data_valid, bus0.rd_data);
      end
   endtask

   initial begin
      test_reset();
      test_reads_only();
      test_mixed();
      test_stall();
      test_reset_in_turn();
      test_rd_return();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule

// File: doc/fb_sram_arbiter.md
Name: fb_sram_arbiter

Overview:
Shares one framebuffer SRAM controller command port between two requesters. The read requester is the VGA scanline prefetch; the write requester is the ADC XY pixel plotter. Reads have priority, writes have a bounded wait, and idle cycles are inserted on every read/write direction change for data-bus turnaround. Sits between the display/plot pipelines and the per-SRAM controller in the ADC XY VGA design; one instance per SRAM.

Parameters:
ADDR_BITS, 20, SRAM word address width
DATA_BITS, 16, SRAM word width
MAX_RD_BURST, 8, max consecutive reads granted while a write is pending (>=1)
TURN_CYCLES, 1, idle cycles inserted on direction change (0 allowed = no gap)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
rd_valid  in  1  read request
rd_ready  out  1  read request accepted this cycle
rd_addr  in  ADDR_BITS  read address
wr_valid  in  1  write request
wr_ready  out  1  write request accepted this cycle
wr_addr  in  ADDR_BITS  write address
wr_data  in  DATA_BITS  write data
mem_cmd_valid  out  1  command to SRAM controller valid
mem_cmd_ready  in  1  SRAM controller accepts command
mem_cmd_we  out  1  1=write, 0=read
mem_cmd_addr  out  ADDR_BITS  command address
mem_cmd_wdata  out  DATA_BITS  write data (0 on reads)
mem_rd_valid  in  1  read data return from controller (in order)
mem_rd_data  in  DATA_BITS  read data
rd_data_valid  out  1  read data to reader
rd_data  out  DATA_BITS  read data to reader

Behaviour:
- Reset (async assert, sync release): mem_cmd_valid=0, mem_cmd_we=0, mem_cmd_addr=0, mem_cmd_wdata=0. rd_ready=0, wr_ready=0. State=ARB, last_dir=READ, burst_cnt=0, turn_cnt=0. Reset mid-transaction drops mem_cmd_valid immediately. A pending command is discarded, not replayed.
- Command output register: one entry. It is "free" when !mem_cmd_valid or mem_cmd_ready. While mem_cmd_valid && !mem_cmd_ready, all mem_cmd_* hold stable and no request is accepted.
- Latency: a request accepted (valid&&ready) in cycle N appears on mem_cmd_* in cycle N+1.
- rd_ready/wr_ready are combinational from state, pick and register-free. They are never both 1.
- Pick rule: pick=READ if rd_valid && (!wr_valid || burst_cnt < MAX_RD_BURST). Otherwise pick=WRITE if wr_valid. Otherwise none.
- States:
  - ARB:
    - pick==last_dir and register free: assert that requester's ready and load register.
    - pick!=last_dir and TURN_CYCLES>0: go to TURN, turn_cnt=TURN_CYCLES, latch new_dir=pick. Nothing is accepted this cycle.
    - pick!=last_dir and TURN_CYCLES==0: accept immediately.
  - TURN: accept nothing. Decrement turn_cnt each cycle. TURN starts only once the output register is free; a held command stays stalled before TURN begins. When turn_cnt reaches 1, go to GRANT with last_dir=new_dir.
  - GRANT: accept the requester of last_dir when the register is free, then go to ARB. If that requester has dropped valid, go to ARB without accepting.
- burst_cnt:
  - increments (saturating at MAX_RD_BURST) on each read accept while wr_valid=1.
  - cleared on a write accept or whenever wr_valid=0.
- After a starvation-forced write, burst_cnt=0, so a waiting read wins the next pick. Writes continue back-to-back while rd_valid=0.
- Simultaneous rd_valid and wr_valid with burst_cnt<MAX_RD_BURST: read wins.
- Read return: rd_data_valid=mem_rd_valid and rd_data=mem_rd_data, combinational passthrough. Only the reader issues reads, so no tagging is needed.
- Requesters must hold valid/addr/data stable until ready. The arbiter does not check this.

Decomposition:
- Shared package fb_arb_pkg: enum arb_state_t {ARB, TURN, GRANT}; enum dir_t {DIR_READ, DIR_WRITE}.
- No sub-module. The output command register is inline.

Test Plan:
- Reads only, mem_cmd_ready=1, rd_valid held 10 cycles: 10 back-to-back reads, each mem_cmd_valid one cycle after rd_ready, mem_cmd_we=0, no gaps.
- rd_valid and wr_valid held continuously, MAX_RD_BURST=8, TURN_CYCLES=1:
  - repeating pattern is 8 reads, 1 idle, 1 write, 1 idle.
  - wr_ready pulses once per 11 cycles.
- TURN_CYCLES=0, same stimulus: 8 reads then 1 write repeating, with no idle cycles.
- Write accepted with mem_cmd_ready=0 for 4 cycles:
  - mem_cmd_addr=0x12345 and mem_cmd_wdata=0xBEEF stay stable.
  - rd_ready and wr_ready stay 0 throughout.
  - next accept occurs the cycle mem_cmd_ready=1.
- reset_n asserted in TURN with mem_cmd_valid=1: mem_cmd_valid=0 in the same cycle. After release: state ARB, last_dir=READ, and the first read is accepted without a turn gap.
- mem_rd_valid pulsed with mem_rd_data=0xA5A5: rd_data_valid=1 and rd_data=0xA5A5 in the same cycle.
